dsp_column_frame_loader: RTL and testbench

Per-column configuration frame loader for the DSP column. It sits directly upstream of the DSP column's north terminal tile and drives the FrameData/FrameStrobe bus that runs down through the terminal tile into the DSP tiles. It accepts addressed frame words over a valid/ready stream and filters them by column index. It then presents each word on FrameData with setup and hold margins and pulses exactly one one-hot FrameStrobe line.

---
 rtl/dsp_cfg_pkg.sv | 23 ++
 rtl/dsp_column_frame_loader_strobe_decoder.sv | 20 ++
 rtl/dsp_column_frame_loader.sv | 134 +++++++++++++
 tb/tb_dsp_column_frame_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dsp_cfg_pkg.sv
// Shared types and defaults for the DSP column frame loader.
// Includes the FSM state encoding and the even-parity helper.
package dsp_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_FRAME_BITS  = 32;
  localparam int DEF_MAX_FRAMES  = 20;
  localparam int DEF_COL_ADDR_W  = 5;
  localparam int DEF_FRAME_IDX_W = 5;
  localparam int COUNT_W         = 16;

  // Zero-extension leaves the parity unchanged, so any word up to 64 bits fits here.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dsp_column_frame_loader_strobe_decoder.sv
// frame_strobe_decoder: frame index to one-hot FrameStrobe decode with enable.
// Produces all zeros when disabled or when the index is outside 0..MAX_FRAMES-1.
module frame_strobe_decoder #(
  parameter int MAX_FRAMES = 20,
  parameter int IDX_W      = 5
) (
  input  logic                  en,
  input  logic [IDX_W-1:0]      idx,
  output logic [MAX_FRAMES-1:0] onehot
);

  // One-hot decode; out-of-range indexes match no bit.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < MAX_FRAMES; i++) begin
      onehot[i] = en && (int'(idx) == i);
    end
  end

endmodule

// File: rtl/dsp_column_frame_loader.sv
// dsp_column_frame_loader: column-filtered frame loader driving FrameData/FrameStrobe.
// Optional even-parity check on s_data is enabled by defining DSP_FRAME_PARITY_EN.
module dsp_column_frame_loader
  import dsp_cfg_pkg::*;
#(
  parameter int FRAME_BITS    = DEF_FRAME_BITS,
  parameter int MAX_FRAMES    = DEF_MAX_FRAMES,
  parameter int COL_ADDR_W    = DEF_COL_ADDR_W,
  parameter int FRAME_IDX_W   = DEF_FRAME_IDX_W,
  parameter int COLUMN_INDEX  = 0,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                              UserCLK,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [COL_ADDR_W+FRAME_IDX_W-1:0] s_addr,
`ifdef DSP_FRAME_PARITY_EN
  input  logic [FRAME_BITS:0]               s_data,
`else
  input  logic [FRAME_BITS-1:0]             s_data,
`endif
  output logic [FRAME_BITS-1:0]             FrameData_O,
  output logic [MAX_FRAMES-1:0]             FrameStrobe_O,
  output logic                              busy,
  output logic                              err_pulse,
  output logic [COUNT_W-1:0]                frame_count
);

  localparam int CNT_W = 4;
  localparam logic [COL_ADDR_W-1:0] MY_COL = COL_ADDR_W'(COLUMN_INDEX);

  state_t                  state;
  state_t                  state_next;
  logic [FRAME_IDX_W-1:0]  idx;
  logic [CNT_W-1:0]        cnt;
  logic [COL_ADDR_W-1:0]   col_field;
  logic [FRAME_IDX_W-1:0]  idx_field;
  logic                    accept;
  logic                    col_match;
  logic                    idx_ok;
  logic                    par_ok;
  logic                    load;
  logic                    err_next;
  logic [MAX_FRAMES-1:0]   strobe_next;

  assign col_field = s_addr[COL_ADDR_W+FRAME_IDX_W-1 -: COL_ADDR_W];
  assign idx_field = s_addr[FRAME_IDX_W-1:0];
  assign accept    = s_valid && s_ready;
  assign col_match = (col_field == MY_COL);
  assign idx_ok    = (int'(idx_field) < MAX_FRAMES);

`ifdef DSP_FRAME_PARITY_EN
  assign par_ok = (s_data[FRAME_BITS] == even_parity(64'(s_data[FRAME_BITS-1:0])));
`else
  assign par_ok = 1'b1;
`endif

  // Strobe is registered alongside the state, so it is high exactly while in STROBE.
  frame_strobe_decoder #(
    .MAX_FRAMES(MAX_FRAMES),
    .IDX_W     (FRAME_IDX_W)
  ) u_decoder (
    .en    (state_next == STROBE),
    .idx   (idx),
    .onehot(strobe_next)
  );

  // Next-state and accept decisions; parity failure and bad index share one error pulse.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && col_match) begin
          if (!par_ok || !idx_ok) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            load       = 1'b1;
            state_next = SETUP;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SETUP: state_next = STROBE;
      STROBE: begin
        if (cnt == {CNT_W{1'b0}}) begin
          state_next = HOLD;
        end else begin
          state_next = STROBE;
        end
      end
      HOLD: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, registered outputs, strobe down-counter and saturating frame counter.
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      FrameData_O   <= '0;
      FrameStrobe_O <= '0;
      s_ready       <= 1'b0;
      busy          <= 1'b0;
      err_pulse     <= 1'b0;
      frame_count   <= '0;
    end else begin
      state         <= state_next;
      FrameStrobe_O <= strobe_next;
      s_ready       <= (state_next == IDLE);
      busy          <= (state_next != IDLE);
      err_pulse     <= err_next;
      if (load) begin
        FrameData_O <= s_data[FRAME_BITS-1:0];
        idx         <= idx_field;
      end
      if (state == SETUP) begin
        cnt <= CNT_W'(STROBE_CYCLES - 1);
      end else if (state == STROBE && cnt != {CNT_W{1'b0}}) begin
        cnt <= cnt - 1'b1;
      end
      if (state == HOLD && frame_count != {COUNT_W{1'b1}}) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dsp_column_frame_loader.sv
// Directed self-checking bench for dsp_column_frame_loader (COLUMN_INDEX=0, STROBE_CYCLES=2).
// The parity scenario is compiled in only when DSP_FRAME_PARITY_EN is defined.
module tb_dsp_column_frame_loader;

  logic        UserCLK;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [9:0]  s_addr;
`ifdef DSP_FRAME_PARITY_EN
  logic [32:0] s_data;
`else
  logic [31:0] s_data;
`endif
  logic [31:0] FrameData_O;
  logic [19:0] FrameStrobe_O;
  logic        busy;
  logic        err_pulse;
  logic [15:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  dsp_column_frame_loader #(
    .FRAME_BITS   (32),
    .MAX_FRAMES   (20),
    .COL_ADDR_W   (5),
    .FRAME_IDX_W  (5),
    .COLUMN_INDEX (0),
    .STROBE_CYCLES(2)
  ) dut (
    .UserCLK      (UserCLK),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_addr       (s_addr),
    .s_data       (s_data),
    .FrameData_O  (FrameData_O),
    .FrameStrobe_O(FrameStrobe_O),
    .busy         (busy),
    .err_pulse    (err_pulse),
    .frame_count  (frame_count)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] col, input logic [4:0] fi, input logic [31:0] d);
    s_valid = v;
    s_addr  = {col, fi};
`ifdef DSP_FRAME_PARITY_EN
    s_data  = {^d, d};
`else
    s_data  = d;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 32'h0);
    repeat (3) step();
    n_tests++; if (FrameData_O !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want %h", FrameData_O, 32'h0); end
    n_tests++; if (FrameStrobe_O !== 20'h0) begin n_fail++; $display("FAIL reset_strobe got %h want %h", FrameStrobe_O, 20'h0); end
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", s_ready); end
    n_tests++; if ({busy, err_pulse} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_err got %b want 00", {busy, err_pulse}); end
    n_tests++; if (frame_count !== 16'h0) begin n_fail++; $display("FAIL reset_count got %h want 0", frame_count); end
    rst = 1'b0;
    step();
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", s_ready); end
  endtask

  task automatic test_write();
    logic [19:0] exp_strobe [0:5];
    logic        exp_ready  [0:5];
    exp_strobe = '{20'h0, 20'h0, 20'h00008, 20'h00008, 20'h0, 20'h0};
    exp_ready  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b1, 5'd0, 5'd3, 32'hDEADBEEF);
    for (int c = 0; c <= 5; c++) begin
      n_tests++; if (FrameStrobe_O !== exp_strobe[c]) begin n_fail++; $display("FAIL write_strobe c%0d got %h want %h", c, FrameStrobe_O, exp_strobe[c]); end
      n_tests++; if (s_ready !== exp_ready[c]) begin n_fail++; $display("FAIL write_ready c%0d got %b want %b", c, s_ready, exp_ready[c]); end
      if (c >= 1) begin
        n_tests++; if (FrameData_O !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_data c%0d got %h want DEADBEEF", c, FrameData_O); end
      end
      step();
      if (c == 0) drive(1'b0, 5'd0, 5'd0, 32'h0);
    end
    n_tests++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL write_count got %0d want 1", frame_count); end
  endtask

  task automatic test_other_column();
    drive(1'b1, 5'd1, 5'd3, 32'h12345678);
    step();
    drive(1'b0, 5'd0, 5'd0, 32'h0);
    n_tests++; if (s_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL othercol_idle got ready=%b busy=%b want 1/0", s_ready, busy); end
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (FrameStrobe_O !== 20'h0 || err_pulse !== 1'b0) begin n_fail++; $display("FAIL othercol_quiet c%0d got strobe=%h err=%b want 0/0", c, FrameStrobe_O, err_pulse); end
      step();
    end
    n_tests++; if (FrameData_O !== 32'hDEADBEEF) begin n_fail++; $display("FAIL othercol_data got %h want DEADBEEF", FrameData_O); end
    n_tests++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL othercol_count got %0d want 1", frame_count); end
  endtask

  task automatic test_bad_index();
    drive(1'b1, 5'd0, 5'd20, 32'hAAAA5555);
    step();
    drive(1'b0, 5'd0, 5'd0, 32'h0);
    n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL badidx_err got %b want 1", err_pulse); end
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL badidx_ready got %b want 1", s_ready); end
    step();
    n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL badidx_err_len got %b want 0", err_pulse); end
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (FrameStrobe_O !== 20'h0) begin n_fail++; $display("FAIL badidx_strobe c%0d got %h want 0", c, FrameStrobe_O); end
      step();
    end
    n_tests++; if (FrameData_O !== 32'hDEADBEEF || frame_count !== 16'd1) begin n_fail++; $display("FAIL badidx_state got data=%h count=%0d want DEADBEEF/1", FrameData_O, frame_count); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    for (int t = 0; t <= 15; t++) begin
      if (t == 0)       drive(1'b1, 5'd0, 5'd0, 32'hA0A0A0A0);
      else if (t == 5)  drive(1'b1, 5'd0, 5'd1, 32'hA1A1A1A1);
      else if (t == 10) drive(1'b1, 5'd0, 5'd2, 32'hA2A2A2A2);
      else if (t < 10)  drive(1'b1, 5'd0, 5'd9, 32'hBAD0BAD0 + t);
      else              drive(1'b0, 5'd0, 5'd0, 32'h0);
      if (t == 2 || t == 3)        exp = 20'h00001;
      else if (t == 7 || t == 8)   exp = 20'h00002;
      else if (t == 12 || t == 13) exp = 20'h00004;
      else                         exp = 20'h0;
      n_tests++; if (FrameStrobe_O !== exp) begin n_fail++; $display("FAIL b2b_strobe t%0d got %h want %h", t, FrameStrobe_O, exp); end
      n_tests++; if ($countones(FrameStrobe_O) > 1) begin n_fail++; $display("FAIL b2b_onehot t%0d got %h want at most one bit", t, FrameStrobe_O); end
      if (t == 4) begin
        n_tests++; if (FrameData_O !== 32'hA0A0A0A0) begin n_fail++; $display("FAIL b2b_data0 got %h want A0A0A0A0", FrameData_O); end
      end
      if (t == 6) begin
        n_tests++; if (FrameData_O !== 32'hA1A1A1A1) begin n_fail++; $display("FAIL b2b_data1 got %h want A1A1A1A1", FrameData_O); end
      end
      if (t == 11) begin
        n_tests++; if (FrameData_O !== 32'hA2A2A2A2) begin n_fail++; $display("FAIL b2b_data2 got %h want A2A2A2A2", FrameData_O); end
      end
      step();
    end
    n_tests++; if (frame_count !== 16'd4 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_count got count=%0d busy=%b want 4/0", frame_count, busy); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd0, 5'd7, 32'h77777777);
    step();
    drive(1'b0, 5'd0, 5'd0, 32'h0);
    step();
    n_tests++; if (FrameStrobe_O !== 20'h00080) begin n_fail++; $display("FAIL rstmid_strobe1 got %h want 00080", FrameStrobe_O); end
    step();
    n_tests++; if (FrameStrobe_O !== 20'h00080) begin n_fail++; $display("FAIL rstmid_strobe2 got %h want 00080", FrameStrobe_O); end
    rst = 1'b1;
    step();
    n_tests++; if (FrameStrobe_O !== 20'h0) begin n_fail++; $display("FAIL rstmid_strobe_drop got %h want 0", FrameStrobe_O); end
    n_tests++; if (frame_count !== 16'd0 || FrameData_O !== 32'h0) begin n_fail++; $display("FAIL rstmid_state got count=%0d data=%h want 0/0", frame_count, FrameData_O); end
    n_tests++; if (s_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got ready=%b busy=%b want 0/0", s_ready, busy); end
    rst = 1'b0;
    step();
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_release got %b want 1", s_ready); end
    repeat (3) step();
    n_tests++; if (frame_count !== 16'd0 || FrameStrobe_O !== 20'h0) begin n_fail++; $display("FAIL rstmid_after got count=%0d strobe=%h want 0/0", frame_count, FrameStrobe_O); end
  endtask

`ifdef DSP_FRAME_PARITY_EN
  task automatic test_parity();
    s_valid = 1'b1;
    s_addr  = {5'd0, 5'd5};
    s_data  = {1'b0, 32'h00000001};
    step();
    s_valid = 1'b0;
    n_tests++; if (err_pulse !== 1'b1 || s_ready !== 1'b1) begin n_fail++; $display("FAIL parity_err got err=%b ready=%b want 1/1", err_pulse, s_ready); end
    step();
    n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL parity_err_len got %b want 0", err_pulse); end
    repeat (3) step();
    n_tests++; if (FrameStrobe_O !== 20'h0 || FrameData_O !== 32'h0) begin n_fail++; $display("FAIL parity_drop got strobe=%h data=%h want 0/0", FrameStrobe_O, FrameData_O); end
    s_valid = 1'b1;
    s_data  = {1'b1, 32'h00000001};
    step();
    s_valid = 1'b0;
    n_tests++; if (FrameData_O !== 32'h00000001 || err_pulse !== 1'b0) begin n_fail++; $display("FAIL parity_ok_data got data=%h err=%b want 00000001/0", FrameData_O, err_pulse); end
    step();
    n_tests++; if (FrameStrobe_O !== 20'h00020) begin n_fail++; $display("FAIL parity_ok_strobe got %h want 00020", FrameStrobe_O); end
    repeat (3) step();
    n_tests++; if (frame_count !== 16'd1 || s_ready !== 1'b1) begin n_fail++; $display("FAIL parity_ok_count got count=%0d ready=%b want 1/1", frame_count, s_ready); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_other_column();
    test_bad_index();
    test_back_to_back();
    test_reset_mid();
`ifdef DSP_FRAME_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
